// File: rtl/divf_operand_stage_if.sv
// -----------------------------------------------------------------------------
// divf_operand_stage_if
// Purpose : Bundles the operand-stage handshake and data signals.
// Modports: master - producer/consumer side (drives in_*, out_ready)
//           slave  - the operand stage itself (drives in_ready, out_*, count)
// Signals : in_valid/in_ready/in_a/in_b   - operand pair enqueue handshake
//           out_valid/out_ready/out_a/out_b - head entry dequeue handshake
//           out_special/out_special_result/out_dbz - bypass info for head pair
//           count                          - entries currently held
// -----------------------------------------------------------------------------
interface divf_operand_stage_if #(
   parameter int unsigned DEPTH = 2
) ();
   localparam int unsigned AW = $clog2(DEPTH);

   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_a;
   logic [31:0]   in_b;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_a;
   logic [31:0]   out_b;
   logic          out_special;
   logic [31:0]   out_special_result;
   logic          out_dbz;
   logic [AW:0]   count;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_special, out_special_result,
             out_dbz, count
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_a, out_b, out_special, out_special_result,
             out_dbz, count
   );
endinterface

// File: rtl/divf_operand_stage.sv
// -----------------------------------------------------------------------------
// divf_operand_stage
// Purpose : Buffered issue stage in front of the combinational binary32 divider.
//           Queues operand pairs in a DEPTH-entry FIFO and classifies each pair
//           at enqueue so pairs the divider cannot handle (zero, inf, NaN,
//           denormal) carry a precomputed result for a downstream bypass mux.
// Ports   : clk - rising-edge clock
//           rst - synchronous active-high reset
//           bus - divf_operand_stage_if.slave (handshakes, operands, head info)
// -----------------------------------------------------------------------------
module divf_operand_stage #(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   divf_operand_stage_if.slave   bus
);
   localparam logic [AW:0]  FULL_CNT = DEPTH[AW:0];
   localparam logic [31:0]  QNAN     = 32'h7FC0_0000;

   // Entry storage; never reset, qualified by r_count.
   logic [31:0]   r_a   [DEPTH];
   logic [31:0]   r_b   [DEPTH];
   logic [31:0]   r_res [DEPTH];
   logic          r_spec[DEPTH];
   logic          r_dbz [DEPTH];

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   logic          w_in_ready;
   logic          w_out_valid;
   logic          w_push;
   logic          w_pop;

   logic          w_spec;
   logic          w_dbz;
   logic [31:0]   w_res;

   // in_ready depends on registered state and rst only, never on out_ready.
   assign w_in_ready  = !rst && (r_count < FULL_CNT);
   assign w_out_valid = (r_count != '0);
   assign w_push      = bus.in_valid && w_in_ready;
   assign w_pop       = w_out_valid && bus.out_ready && !rst;

   // Operand classification; exp==0 is treated as zero (denormals flush).
   always_comb begin
      logic       w_s;
      logic       w_a_zero, w_a_inf, w_a_nan;
      logic       w_b_zero, w_b_inf, w_b_nan;
      w_s      = bus.in_a[31] ^ bus.in_b[31];
      w_a_zero = (bus.in_a[30:23] == 8'h00);
      w_a_inf  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] == '0);
      w_a_nan  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] != '0);
      w_b_zero = (bus.in_b[30:23] == 8'h00);
      w_b_inf  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] == '0);
      w_b_nan  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] != '0);
      w_spec   = 1'b1;
      w_dbz    = 1'b0;
      w_res    = '0;
      if (w_a_nan || w_b_nan) begin
         w_res = QNAN;
      end else if ((w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
         w_res = QNAN;
      end else if (w_a_inf) begin
         w_res = {w_s, 8'hFF, 23'h0};
      end else if (w_b_zero) begin
         // a is finite nonzero here.
         w_res = {w_s, 8'hFF, 23'h0};
         w_dbz = 1'b1;
      end else if (w_a_zero || w_b_inf) begin
         w_res = {w_s, 31'h0};
      end else begin
         w_spec = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_a[r_wptr]    <= bus.in_a;
         r_b[r_wptr]    <= bus.in_b;
         r_res[r_wptr]  <= w_res;
         r_spec[r_wptr] <= w_spec;
         r_dbz[r_wptr]  <= w_dbz;
      end
   end

   always_comb begin
      bus.in_ready           = w_in_ready;
      bus.out_valid          = w_out_valid;
      bus.count              = r_count;
      bus.out_a              = '0;
      bus.out_b              = '0;
      bus.out_special        = 1'b0;
      bus.out_special_result = '0;
      bus.out_dbz            = 1'b0;
      if (w_out_valid) begin
         bus.out_a              = r_a[r_rptr];
         bus.out_b              = r_b[r_rptr];
         bus.out_special        = r_spec[r_rptr];
         bus.out_special_result = r_res[r_rptr];
         bus.out_dbz            = r_dbz[r_rptr];
      end
   end
endmodule

// File: doc/divf_operand_stage.md
Name: divf_operand_stage

Overview:
- Buffered issue stage directly upstream of the combinational single-precision divider (divf).
- Accepts IEEE-754 binary32 operand pairs (dividend a, divisor b) over a valid/ready handshake and queues them in a small FIFO.
- Classifies each pair at enqueue. Pairs the divider cannot handle (zero, inf, NaN, denormal) are flagged, and a precomputed special result is carried with them, so the downstream mux can bypass divf for those pairs.
- Gives the divider a registered, stall-tolerant operand source.

Parameters:
- DEPTH, 2: FIFO entries; power of two, 2..8.
- AW, $clog2(DEPTH): pointer width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  producer has an operand pair
- in_ready  out  1  stage can accept a pair this cycle
- in_a  in  32  dividend, binary32
- in_b  in  32  divisor, binary32
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes head entry this cycle
- out_a  out  32  head dividend, to divf a
- out_b  out  32  head divisor, to divf b
- out_special  out  1  head pair must bypass divf
- out_special_result  out  32  result to use when out_special=1, else 0
- out_dbz  out  1  head pair is finite nonzero / zero (divide-by-zero)
- count  out  AW+1  entries currently held

Behaviour:
- Reset (rst=1 at an edge):
  - Pointers, count and all entry valid state clear.
  - Stored data does not need clearing.
  - After reset: out_valid=0, count=0, and out_a, out_b, out_special, out_special_result and out_dbz all read 0.
  - in_ready=0 during any cycle in which rst=1, and 1 in the first cycle after reset.
  - Reset mid-operation discards all queued entries and any in-flight handshake; nothing is accepted or dequeued in that cycle.
- Handshake:
  - Enqueue when in_valid && in_ready.
  - Dequeue when out_valid && out_ready.
  - in_ready = (count < DEPTH). It is a function of registered state only, never of out_ready, so there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - When full, a same-cycle dequeue does not allow an enqueue.
  - When neither count==0 nor count==DEPTH, a simultaneous enqueue and dequeue leaves count unchanged and advances both pointers.
  - Pointers wrap modulo DEPTH.
- Latency and ordering:
  - A pair accepted at edge N appears on out_* in the cycle after edge N when the FIFO was empty. There is no same-cycle pass-through.
  - Order is strictly FIFO.
  - Output fields come from the head entry. They are forced to 0 when out_valid=0.
- Classification, computed from in_a/in_b at enqueue and stored with the entry:
  - s = a[31]^b[31].
  - exp==0 counts as zero, regardless of mantissa (denormals flush to zero).
  - inf = exp 0xFF with mantissa 0.
  - NaN = exp 0xFF with mantissa != 0.
- Special rules, in priority order:
  1. Either operand NaN -> 0x7FC00000.
  2. inf/inf or 0/0 -> 0x7FC00000.
  3. inf/finite -> {s, 0xFF, 0}.
  4. finite nonzero/0 -> {s, 0xFF, 0} and dbz=1.
  5. 0/nonzero, or finite/inf -> {s, 31'b0}.
  6. Otherwise special=0, result=0.
- dbz=1 only under rule 4.
- out_a and out_b always carry the original operands unmodified, including for special pairs.
- Holding with out_ready=0: out_valid and all output fields stay stable until the head entry is dequeued.

Test Plan:
- Reset, then a=0x40C00000, b=0x40000000, in_valid for 1 cycle -> next cycle out_valid=1, out_a=0x40C00000, out_b=0x40000000, out_special=0, out_dbz=0, count=1.
- DEPTH=2, out_ready=0, offer 3 pairs back-to-back -> first two accepted, in_ready=0 with count=2. Third pair is held by the producer. After one dequeue it is accepted. Output order matches input order.
- a=0x3F800000, b=0x80000000 -> out_special=1, out_special_result=0xFF800000, out_dbz=1.
- a=0x7FC00001, b=0x3F800000 -> out_special_result=0x7FC00000. Then a=0x00000000, b=0x00000000 -> 0x7FC00000, out_dbz=0.
- a=0x80000000, b=0x40400000 -> out_special_result=0x80000000. Then a=0x00000001 (denormal), b=0x3F800000 -> out_special=1, result=0x00000000.
- Full FIFO, assert rst for 1 cycle with in_valid=1 and out_ready=1 -> after reset count=0, out_valid=0, and the offered pair is not captured.
